block_cmd_scheduler: RTL and testbench



---
 rtl/block_cmd_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_block_cmd_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_cmd_scheduler.sv
// block_cmd_scheduler: queues sprite-update commands from the HPS bridge and
// broadcasts them one per cycle on the display command bus. Every command is
// stamped with the current back-buffer index. Commit markers are held at the
// FIFO head until the next vertical-blank start, and then become a single
// buffer-swap word, so each frame's updates appear atomically.
module block_cmd_scheduler #(
  parameter int DEPTH    = 64,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_word,
  output logic        frame_irq
);

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW        = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]   ZERO_CNT  = {CW{1'b0}};
  localparam logic [CW-1:0]   ONE_CNT   = CW'(1);
  localparam logic [AW-1:0]   ONE_PTR   = AW'(1);
  localparam logic [9:0]      VBL_LINE  = 10'(V_ACTIVE);
  localparam logic [31:0]     SWAP_BASE = 32'h001E_0000;  // info field = 4'hF

  typedef enum logic [1:0] {
    ST_DRAIN    = 2'd0,
    ST_WAIT_VBL = 2'd1,
    ST_SWAP     = 2'd2
  } state_e;

  // Registered state
  state_e          state_q, state_d;
  logic            front_q, front_d;
  logic            overflow_q, overflow_d;
  logic            vbl_prev_q, vbl_prev_d;
  logic [31:0]     cmd_word_q, cmd_word_d;
  logic            frame_irq_q, frame_irq_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [32:0]     fifo_mem_q [DEPTH];

  // Combinational helpers
  logic            back;
  logic            vbl_cond;
  logic            vblank_start;
  logic            push_req;
  logic            push_ok;
  logic            clr_ovf;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic [32:0]     push_entry;
  logic [32:0]     head_entry;
  logic            head_marker;
  logic [31:0]     back_stamp;

  assign back        = ~front_q;
  assign back_stamp  = {18'h0_0000, back, 13'h0000};
  assign fifo_full   = (count_q == FULL_CNT);
  assign fifo_empty  = (count_q == ZERO_CNT);
  assign head_entry  = fifo_mem_q[rd_ptr_q];
  assign head_marker = head_entry[32];

  // Vertical-blank start detection: one pulse on the rising edge of the
  // (vcount==V_ACTIVE && hcount==0) condition, even if hcount stalls at 0.
  always_comb begin
    vbl_cond     = (vcount == VBL_LINE) && (hcount == 10'd0);
    vblank_start = vbl_cond && !vbl_prev_q;
    vbl_prev_d   = vbl_cond;
  end

  // Avalon write decode; bit13 is stored as 0 so the back index can be OR'ed in on issue.
  always_comb begin
    push_req = chipselect & write & ~address[1];
    clr_ovf  = chipselect & write & (address == 2'd2);
    push_ok  = push_req & ~fifo_full;
    if (address[0]) begin
      push_entry = {1'b1, 32'h0000_0000};
    end else begin
      push_entry = {1'b0, writedata[31:14], 1'b0, writedata[12:0]};
    end
  end

  // Sticky overflow: a push against a full FIFO sets it, an address-2 write clears it.
  always_comb begin
    overflow_d = overflow_q;
    if (push_req && fifo_full) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Scheduler FSM: drains commands, parks on a marker, swaps at vblank start.
  always_comb begin
    state_d     = state_q;
    cmd_word_d  = 32'h0000_0000;
    frame_irq_d = 1'b0;
    front_d     = front_q;
    pop         = 1'b0;
    case (state_q)
      ST_DRAIN: begin
        if (fifo_empty) begin
          cmd_word_d = 32'h0000_0000;
        end else if (head_marker) begin
          // Marker stays at the head until its swap is issued.
          state_d = ST_WAIT_VBL;
        end else begin
          pop        = 1'b1;
          cmd_word_d = head_entry[31:0] | back_stamp;
        end
      end
      ST_WAIT_VBL: begin
        if (vblank_start) begin
          state_d = ST_SWAP;
        end else begin
          state_d = ST_WAIT_VBL;
        end
      end
      ST_SWAP: begin
        // Swap word carries the new front index (the current back) in bit13.
        cmd_word_d  = SWAP_BASE | back_stamp;
        frame_irq_d = 1'b1;
        front_d     = ~front_q;
        pop         = ~fifo_empty;
        state_d     = ST_DRAIN;
      end
      default: begin
        state_d = ST_DRAIN;
      end
    endcase
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Status word for software reads; zero when not being read.
  always_comb begin
    if (chipselect && read) begin
      readdata = {16'(count_q), 12'h000, state_q, front_q, overflow_q};
    end else begin
      readdata = 32'h0000_0000;
    end
  end

  // Control, status and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_DRAIN;
      front_q     <= 1'b0;
      overflow_q  <= 1'b0;
      vbl_prev_q  <= 1'b0;
      cmd_word_q  <= 32'h0000_0000;
      frame_irq_q <= 1'b0;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= ZERO_CNT;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      overflow_q  <= overflow_d;
      vbl_prev_q  <= vbl_prev_d;
      cmd_word_q  <= cmd_word_d;
      frame_irq_q <= frame_irq_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; entries need no reset since count and pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign cmd_word  = cmd_word_q;
  assign frame_irq = frame_irq_q;

endmodule

// File: tb/tb_block_cmd_scheduler.sv
// Bench for block_cmd_scheduler: table-driven vectors, hand-written corner
// sequences and a randomized phase, all compared against a queue-based model.
module tb_block_cmd_scheduler;

  localparam int DEPTH    = 16;
  localparam int V_ACTIVE = 480;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [31:0] cmd_word;
  logic        frame_irq;

  always #5 clk = ~clk;

  block_cmd_scheduler #(.DEPTH(DEPTH), .V_ACTIVE(V_ACTIVE)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .hcount     (hcount),
    .vcount     (vcount),
    .cmd_word   (cmd_word),
    .frame_irq  (frame_irq)
  );

  int n_checks = 0;
  int n_errors = 0;
  int irq_seen = 0;

  // Reference model: queue of {marker, word}; phase 0=draining, 1=waiting, 2=swapping.
  logic [32:0] mq[$];
  logic        m_front = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_prev_vbl = 1'b0;
  int          m_phase = 0;
  logic [31:0] exp_cmd = 32'h0;
  logic        exp_irq = 1'b0;

  typedef struct {
    logic        cs;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_cmd;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {16'(mq.size()), 12'h000, 2'(m_phase), m_front, m_ovf};
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic        vbl_now;
    logic        vbl_start;
    int          size_before;
    logic [32:0] e;
    logic [31:0] w;
    exp_cmd = 32'h0;
    exp_irq = 1'b0;
    if (reset) begin
      mq.delete();
      m_front    = 1'b0;
      m_ovf      = 1'b0;
      m_phase    = 0;
      m_prev_vbl = 1'b0;
    end else begin
      vbl_now     = (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);
      vbl_start   = vbl_now && !m_prev_vbl;
      size_before = mq.size();
      if (m_phase == 0) begin
        if (size_before > 0) begin
          if (mq[0][32]) begin
            m_phase = 1;
          end else begin
            e = mq.pop_front();
            w = e[31:0];
            w[13] = ~m_front;
            exp_cmd = w;
          end
        end
      end else if (m_phase == 1) begin
        if (vbl_start) m_phase = 2;
      end else begin
        void'(mq.pop_front());
        w = 32'h001E0000;
        w[13] = ~m_front;
        exp_cmd = w;
        exp_irq = 1'b1;
        m_front = ~m_front;
        m_phase = 0;
      end
      if (chipselect && write && (address < 2'd2)) begin
        if (size_before == DEPTH) m_ovf = 1'b1;
        else mq.push_back((address == 2'd1) ? {1'b1, 32'h0} : {1'b0, writedata});
      end
      if (chipselect && write && (address == 2'd2)) m_ovf = 1'b0;
      m_prev_vbl = vbl_now;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("cmd_word", cmd_word, exp_cmd);
    chk("frame_irq", {31'h0, frame_irq}, {31'h0, exp_irq});
    if (frame_irq) irq_seen++;
  endtask

  task automatic set_idle();
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = 2'd0;
    writedata  = 32'h0;
  endtask

  task automatic push(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    tick();
    set_idle();
  endtask

  task automatic check_status();
    chipselect = 1'b1;
    write      = 1'b0;
    read       = 1'b1;
    #1;
    chk("status", readdata, model_status());
    read       = 1'b0;
    chipselect = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    set_idle();
    vcount = 10'd0;
    hcount = 10'd0;
    tick();
    tick();
    reset = 1'b0;
    check_status();
    chk("reset_status", readdata, 32'h0);
    read = 1'b1; chipselect = 1'b1; #1;
    chk("reset_status_raw", readdata, 32'h0);
    set_idle();

    // Two back-to-back commands, stamped with back=1, one-cycle latency.
    tbl[0] = '{1'b1, 1'b1, 2'd0, 32'h08220000, 32'h00000000};
    tbl[1] = '{1'b1, 1'b1, 2'd0, 32'h08240003, 32'h08222000};
    tbl[2] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 32'h08242003};
    tbl[3] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      chipselect = tbl[i].cs;
      write      = tbl[i].wr;
      address    = tbl[i].addr;
      writedata  = tbl[i].wdata;
      tick();
      chk("tbl_cmd", cmd_word, tbl[i].exp_cmd);
    end
    set_idle();

    // Three commands, commit, two commands; swap at vblank start.
    vcount = 10'd100; hcount = 10'd5;
    push(2'd0, 32'h04000001);
    push(2'd0, 32'h04002002);
    chk("pre_swap_w1", cmd_word, 32'h04002001);
    push(2'd0, 32'h04000003);
    chk("pre_swap_w2", cmd_word, 32'h04002002);
    push(2'd1, 32'h0);
    chk("pre_swap_w3", cmd_word, 32'h04002003);
    push(2'd0, 32'h0C000004);
    push(2'd0, 32'h0C002005);
    vcount = 10'd479;
    repeat (3) tick();
    vcount = 10'd480; hcount = 10'd0;
    tick();
    chk("no_swap_yet", cmd_word, 32'h0);
    hcount = 10'd1;
    tick();
    chk("swap_word", cmd_word, 32'h001E2000);
    chk("swap_irq", {31'h0, frame_irq}, 32'h1);
    tick();
    chk("post_swap_w4", cmd_word, 32'h0C000004);
    tick();
    chk("post_swap_w5", cmd_word, 32'h0C000005);
    check_status();
    read = 1'b1; chipselect = 1'b1; #1;
    chk("front_after_swap", {31'h0, readdata[1]}, 32'h1);
    set_idle();
    vcount = 10'd0;
    tick();

    // Two markers; vblank condition held 5 cycles gives exactly one swap.
    push(2'd1, 32'h0);
    push(2'd1, 32'h0);
    tick();
    irq_seen = 0;
    vcount = 10'd480; hcount = 10'd0;
    repeat (5) tick();
    vcount = 10'd0;
    repeat (3) tick();
    chk("one_swap_per_frame", 32'(irq_seen), 32'd1);
    vcount = 10'd480;
    repeat (2) tick();
    vcount = 10'd0;
    repeat (2) tick();
    chk("second_frame_swap", 32'(irq_seen), 32'd2);
    check_status();

    // Overflow while stalled behind a marker, then clear.
    push(2'd1, 32'h0);
    tick();
    for (int i = 0; i < DEPTH + 1; i++) push(2'd0, 32'hA0000000 + 32'(i));
    check_status();
    read = 1'b1; chipselect = 1'b1; #1;
    chk("full_count", {16'h0, readdata[31:16]}, 32'(DEPTH));
    chk("overflow_set", {31'h0, readdata[0]}, 32'h1);
    set_idle();
    push(2'd2, 32'h0);
    check_status();
    read = 1'b1; chipselect = 1'b1; #1;
    chk("overflow_clr", {31'h0, readdata[0]}, 32'h0);
    set_idle();

    // Push at count==DEPTH in the same cycle as the marker pop.
    vcount = 10'd480; hcount = 10'd0;
    tick();
    vcount = 10'd0;
    push(2'd0, 32'hBAD00000);
    check_status();
    read = 1'b1; chipselect = 1'b1; #1;
    chk("full_pop_count", {16'h0, readdata[31:16]}, 32'(DEPTH - 1));
    chk("full_pop_ovf", {31'h0, readdata[0]}, 32'h1);
    set_idle();
    repeat (DEPTH + 2) tick();

    // Reset during WAIT_VBL with 10 entries queued.
    push(2'd1, 32'h0);
    for (int i = 0; i < 9; i++) push(2'd0, 32'h10000000 + 32'(i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_cmd", cmd_word, 32'h0);
    check_status();
    read = 1'b1; chipselect = 1'b1; #1;
    chk("reset_flush", readdata, 32'h0);
    set_idle();
    irq_seen = 0;
    vcount = 10'd480; hcount = 10'd0;
    repeat (3) tick();
    vcount = 10'd0;
    repeat (2) tick();
    chk("no_swap_after_reset", 32'(irq_seen), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset      = ($urandom_range(0, 399) == 0);
      chipselect = ($urandom_range(0, 3) != 0);
      write      = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 15);
      if (r <= 10)      address = 2'd0;
      else if (r <= 12) address = 2'd1;
      else if (r == 13) address = 2'd2;
      else              address = 2'd3;
      writedata = $urandom();
      vcount    = ($urandom_range(0, 3) == 0) ? 10'd480 : 10'($urandom_range(0, 1023));
      hcount    = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
      read      = 1'b0;
      tick();
      if ((c % 5) == 0) begin
        reset = 1'b0;
        check_status();
      end
    end
    reset = 1'b0;
    set_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
